// File: rtl/wave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wave_pkg
//  Description : Shared definitions for the wave DAC output path: FSM state
//                encoding, DAC command defaults and the frame width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package wave_pkg;

  // Serialiser FSM states (2-bit, legacy-compatible encoding)
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  // DAC command prefix defaults
  localparam int         CMD_WIDTH_DEF = 8;
  localparam logic [7:0] DAC_CMD_DEF   = 8'h30;

  // Number of bits clocked out per chip-select frame
  function automatic int frame_bits(input int cmd_width, input int data_width);
    return cmd_width + data_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO with registered
//                full/empty flags and occupancy. A push while full is only
//                accepted when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 16,
  parameter int AWIDTH = 4
) (
  input  logic              rclk,
  input  logic              r_rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] din,
  input  logic              pop,
  output logic [DWIDTH-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AWIDTH:0]   level
);

  localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH+1)'(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;
  logic [AWIDTH:0]   level_next;

  assign pop_ok     = pop && !empty;
  assign push_ok    = push && (!full || pop_ok);
  assign level_next = level + {{AWIDTH{1'b0}}, push_ok} - {{AWIDTH{1'b0}}, pop_ok};
  assign dout       = mem[rd_ptr];

  // Storage array: written on every accepted push, no reset needed
  always_ff @(posedge rclk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and flags; flags come from the next level so a fresh
  // push into an empty FIFO only becomes visible one cycle later
  always_ff @(posedge rclk or posedge r_rst) begin
    if (r_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_next;
      full  <= (level_next == DEPTH_L);
      empty <= (level_next == '0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/wave_dac_spi.sv
`default_nettype none
// ============================================================================
//  Module      : wave_dac_spi
//  Description : Buffers the wave RAM sample stream and sends each sample to
//                an external DAC as one SPI mode-0 frame {command, sample},
//                MSB first. Reports FIFO level and sticky overflow/underrun.
//  Revision    : 1.0 - initial release
// ============================================================================
module wave_dac_spi
  import wave_pkg::*;
#(
  parameter int                   DWIDTH      = 16,
  parameter int                   CMD_WIDTH   = CMD_WIDTH_DEF,
  parameter logic [CMD_WIDTH-1:0] DAC_CMD     = CMD_WIDTH'(DAC_CMD_DEF),
  parameter int                   FIFO_DEPTH  = 16,
  parameter int                   FIFO_AWIDTH = 4,
  parameter int                   SCLK_DIV    = 2,
  parameter int                   CS_GAP      = 2
) (
  input  logic                   rclk,
  input  logic                   r_rst,
  input  logic [DWIDTH-1:0]      din,
  input  logic                   din_v,
  input  logic                   enable,
  input  logic                   clr_status,
  output logic                   sclk,
  output logic                   cs_n,
  output logic                   mosi,
  output logic                   busy,
  output logic [FIFO_AWIDTH:0]   level,
  output logic                   overflow,
  output logic                   underrun
);

  localparam int FRAME = frame_bits(CMD_WIDTH, DWIDTH);
  localparam int BCW   = $clog2(FRAME);
  localparam int HPW   = $clog2(SCLK_DIV + 1);
  localparam int GW    = $clog2(CS_GAP + 1);

  localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME - 1);
  localparam logic [HPW-1:0] HP_LAST  = HPW'(SCLK_DIV - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(CS_GAP - 1);

  logic [1:0]        state;
  logic [FRAME-1:0]  shreg;
  logic [BCW-1:0]    bit_cnt;
  logic [HPW-1:0]    hp_cnt;
  logic [GW-1:0]     gap_cnt;

  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DWIDTH-1:0] fifo_dout;

  logic              start_ok;
  logic              hp_wrap;
  logic              gap_done;
  logic              overflow_set;
  logic              underrun_set;

  assign fifo_pop     = (state == LOAD);
  assign start_ok     = enable && !fifo_empty;
  assign hp_wrap      = (hp_cnt == HP_LAST);
  assign gap_done     = (state == GAP) && (gap_cnt == GAP_LAST);
  // A push while full is only lost when no pop frees a slot that cycle
  assign overflow_set = din_v && fifo_full && !fifo_pop;
  assign underrun_set = gap_done && enable && fifo_empty;

  sync_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (FIFO_DEPTH),
    .AWIDTH (FIFO_AWIDTH)
  ) u_fifo (
    .rclk  (rclk),
    .r_rst (r_rst),
    .push  (din_v),
    .din   (din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Frame sequencer and shifter: data launches on sclk falling edges so the
  // DAC sees stable bits on every rising edge
  always_ff @(posedge rclk or posedge r_rst) begin
    if (r_rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      hp_cnt  <= '0;
      gap_cnt <= '0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          shreg   <= {DAC_CMD, fifo_dout};
          mosi    <= DAC_CMD[CMD_WIDTH-1];
          cs_n    <= 1'b0;
          sclk    <= 1'b0;
          bit_cnt <= '0;
          hp_cnt  <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (hp_wrap) begin
            hp_cnt <= '0;
            sclk   <= ~sclk;
            if (sclk) begin
              shreg   <= shreg << 1;
              mosi    <= shreg[FRAME-2];
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                state   <= GAP;
                cs_n    <= 1'b1;
                mosi    <= 1'b0;
                gap_cnt <= '0;
              end
            end
          end else begin
            hp_cnt <= hp_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_done) begin
            // Chain straight into the next frame when one is ready
            if (start_ok) begin
              state <= LOAD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky status flags; a clear wins over a set in the same cycle
  always_ff @(posedge rclk or posedge r_rst) begin
    if (r_rst) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else if (clr_status) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (overflow_set) overflow <= 1'b1;
      if (underrun_set) underrun <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wave_dac_spi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wave_dac_spi
//  Description : Directed and randomized bench for wave_dac_spi. An SPI
//                monitor reassembles frames from mosi on sclk rises; a sample
//                queue holds the samples expected on the wire, in order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_dac_spi;

  localparam int         FRAME  = 24;
  localparam int         PERIOD = 99;
  localparam logic [7:0] CMD    = 8'h30;

  logic        rclk;
  logic        r_rst;
  logic [15:0] din;
  logic        din_v;
  logic        enable;
  logic        clr_status;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        busy;
  logic [4:0]  level;
  logic        overflow;
  logic        underrun;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Edge timestamps in rclk cycles
  int csf_q[$];
  int csr_q[$];
  int br_q[$];
  int bf_q[$];
  int sr_q[$];
  logic [23:0] rx_q[$];
  logic [15:0] exp_q[$];

  int csf_base, csr_base, br_base, bf_base, sr_base, rx_base;

  logic [23:0] mon_sh;
  int          mon_bc;

  wave_dac_spi dut (
    .rclk       (rclk),
    .r_rst      (r_rst),
    .din        (din),
    .din_v      (din_v),
    .enable     (enable),
    .clr_status (clr_status),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .busy       (busy),
    .level      (level),
    .overflow   (overflow),
    .underrun   (underrun)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Cycle counter ticking away from the active edge
  always @(negedge rclk) cyc <= cyc + 1;

  // SPI receiver: a chip-select rise discards any partial frame
  always @(posedge sclk or posedge cs_n) begin
    if (cs_n) begin
      mon_bc = 0;
    end else begin
      mon_sh = {mon_sh[22:0], mosi};
      mon_bc = mon_bc + 1;
      sr_q.push_back(cyc);
      if (mon_bc == FRAME) begin
        rx_q.push_back(mon_sh);
        mon_bc = 0;
      end
    end
  end

  always @(negedge cs_n) csf_q.push_back(cyc);
  always @(posedge cs_n) csr_q.push_back(cyc);
  always @(posedge busy) br_q.push_back(cyc);
  always @(negedge busy) bf_q.push_back(cyc);

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (observed running, expected done)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -999;
  endfunction

  task automatic mark();
    csf_base = csf_q.size();
    csr_base = csr_q.size();
    br_base  = br_q.size();
    bf_base  = bf_q.size();
    sr_base  = sr_q.size();
  endtask

  // Caller sits just after a negedge; returns one negedge later
  task automatic push_one(input logic [15:0] d, input bit accept);
    din   = d;
    din_v = 1'b1;
    if (accept) exp_q.push_back(d);
    @(negedge rclk);
    din_v = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    @(negedge rclk);
    clr_status = 1'b0;
  endtask

  task automatic wait_quiet(input int budget, input string tag);
    int n = 0;
    int q = 0;
    while (q < 3 && n < budget) begin
      @(negedge rclk);
      n++;
      if (!busy) q++;
      else q = 0;
    end
    check(tag, 32'(q >= 3), 32'd1);
  endtask

  task automatic wait_cs(input logic v, input int budget, input string tag);
    int n = 0;
    while (cs_n !== v && n < budget) begin
      @(negedge rclk);
      n++;
    end
    check(tag, 32'(cs_n), 32'(v));
  endtask

  // Compare the next n received frames against the oldest n expected samples
  task automatic check_frames(input int n, input string tag);
    check({tag, "_count"}, 32'(rx_q.size() - rx_base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (rx_base + i < rx_q.size() && exp_q.size() > 0) begin
        check({tag, "_data"}, 32'(rx_q[rx_base + i]), 32'({CMD, exp_q[0]}));
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    rx_base = rx_q.size();
  endtask

  initial begin
    logic [15:0] v;
    int n;

    r_rst = 1'b1; din = '0; din_v = 1'b0; enable = 1'b0; clr_status = 1'b0;
    mon_sh = '0; mon_bc = 0; rx_base = 0;
    repeat (3) @(negedge rclk);

    // Reset state
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    r_rst = 1'b0;
    @(negedge rclk);
    rx_base = rx_q.size();
    mark();

    // 1: single sample, frame shape and timing
    enable = 1'b1;
    push_one(16'hA5C3, 1'b1);
    wait_quiet(400, "t1_quiet");
    check_frames(1, "t1");
    check("t1_rises", 32'(sr_q.size() - sr_base), 32'd24);
    check("t1_sclk_period", 32'(qget(sr_q, sr_base + 1) - qget(sr_q, sr_base)), 32'd4);
    check("t1_sclk_span", 32'(qget(sr_q, sr_base + 23) - qget(sr_q, sr_base)), 32'd92);
    check("t1_cs_after_load", 32'(qget(csf_q, csf_base) - qget(br_q, br_base)), 32'd1);
    check("t1_first_bit_lead", 32'(qget(sr_q, sr_base) - qget(csf_q, csf_base)), 32'd2);
    check("t1_cs_high_at", 32'(qget(csr_q, csr_base) - qget(br_q, br_base)), 32'd97);
    check("t1_busy_len", 32'(qget(bf_q, bf_base) - qget(br_q, br_base)), 32'(PERIOD));
    check("t1_underrun", 32'(underrun), 32'd1);
    check("t1_mosi_idle", 32'(mosi), 32'd0);

    // 2: four back-to-back samples
    pulse_clr();
    check("t2_underrun_clr", 32'(underrun), 32'd0);
    mark();
    for (int i = 0; i < 4; i++) begin
      v = 16'($urandom);
      push_one(v, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      wait_cs(1'b0, 300, "t2_cs_low");
      check("t2_level", 32'(level), 32'(3 - i));
      check("t2_underrun_mid", 32'(underrun), 32'd0);
      wait_cs(1'b1, 300, "t2_cs_high");
    end
    wait_quiet(400, "t2_quiet");
    check("t2_underrun_end", 32'(underrun), 32'd1);
    check_frames(4, "t2");
    for (int i = 0; i < 3; i++) begin
      check("t2_spacing", 32'(qget(csf_q, csf_base + i + 1) - qget(csf_q, csf_base + i)), 32'(PERIOD));
      // chip select stays high through the gap and the next load cycle
      check("t2_cs_gap", 32'(qget(csf_q, csf_base + i + 1) - qget(csr_q, csr_base + i)), 32'd3);
    end

    // 3: fill past full with transmission disabled
    enable = 1'b0;
    pulse_clr();
    for (int i = 0; i < 17; i++) begin
      v = 16'($urandom);
      push_one(v, i < 16);
      if (i == 15) begin
        check("t3_level_full", 32'(level), 32'd16);
        check("t3_no_ovf_at_16", 32'(overflow), 32'd0);
      end
    end
    check("t3_level_hold", 32'(level), 32'd16);
    check("t3_overflow", 32'(overflow), 32'd1);
    pulse_clr();
    check("t3_overflow_clr", 32'(overflow), 32'd0);
    enable = 1'b1;
    wait_quiet(2000, "t3_quiet");
    check_frames(16, "t3");
    check("t3_level_empty", 32'(level), 32'd0);

    // 4: push into a full FIFO during the load cycle
    enable = 1'b0;
    pulse_clr();
    for (int i = 0; i < 16; i++) begin
      v = 16'($urandom);
      push_one(v, 1'b1);
    end
    check("t4_level_full", 32'(level), 32'd16);
    enable = 1'b1;
    @(negedge rclk);
    check("t4_busy_load", 32'(busy), 32'd1);
    v = 16'($urandom);
    push_one(v, 1'b1);
    check("t4_level_same", 32'(level), 32'd16);
    check("t4_no_overflow", 32'(overflow), 32'd0);
    wait_quiet(2000, "t4_quiet");
    check_frames(17, "t4");

    // 5: enable dropped mid-frame
    enable = 1'b0;
    pulse_clr();
    for (int i = 0; i < 3; i++) begin
      v = 16'($urandom);
      push_one(v, 1'b1);
    end
    mark();
    enable = 1'b1;
    wait_cs(1'b0, 20, "t5_cs_low");
    repeat (42) @(negedge rclk);
    enable = 1'b0;
    wait_quiet(200, "t5_quiet");
    check_frames(1, "t5");
    check("t5_level", 32'(level), 32'd2);
    repeat (50) @(negedge rclk);
    check("t5_level_hold", 32'(level), 32'd2);
    check("t5_one_frame", 32'(csf_q.size() - csf_base), 32'd1);

    // 6: reset mid-frame while sclk is high
    enable = 1'b1;
    wait_cs(1'b0, 20, "t6_cs_low");
    repeat (48) @(negedge rclk);
    n = 0;
    while (sclk !== 1'b1 && n < 8) begin
      @(negedge rclk);
      n++;
    end
    check("t6_sclk_high", 32'(sclk), 32'd1);
    #2 r_rst = 1'b1;
    #1;
    check("t6_sclk", 32'(sclk), 32'd0);
    check("t6_cs_n", 32'(cs_n), 32'd1);
    check("t6_mosi", 32'(mosi), 32'd0);
    check("t6_level", 32'(level), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    @(negedge rclk);
    r_rst = 1'b0;
    check("t6_partial", 32'(rx_q.size() - rx_base), 32'd0);
    exp_q.delete();
    rx_base = rx_q.size();
    mark();
    repeat (200) @(negedge rclk);
    check("t6_no_frames", 32'(csf_q.size() - csf_base), 32'd0);
    check("t6_idle_busy", 32'(busy), 32'd0);
    check("t6_idle_level", 32'(level), 32'd0);
    v = 16'($urandom);
    push_one(v, 1'b1);
    wait_quiet(400, "t6_quiet");
    check_frames(1, "t6");

    // 7: random samples at random spacing
    pulse_clr();
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 120)) @(negedge rclk);
      v = 16'($urandom);
      push_one(v, 1'b1);
    end
    wait_quiet(1000, "t7_quiet");
    check_frames(6, "t7");
    check("t7_overflow", 32'(overflow), 32'd0);
    check("t7_level", 32'(level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
